// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract D.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rr,
  input  logic         qbit,
  input  logic [N-1:0] d,
  output logic [N-1:0] rr_next,
  output logic         q_next
);

  logic [N:0]   t;
  logic [N-1:0] diff;

  assign t = {rr, qbit};
  // When t >= d the difference is below d, so the low N bits of the subtraction are exact.
  assign diff    = t[N-1:0] - d;
  assign q_next  = (t >= {1'b0, d});
  assign rr_next = q_next ? diff : t[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, 2N/N -> N quotient + N remainder, one quotient bit per cycle.
//  state | meaning
//  IDLE  | in_ready=1, waiting for operands
//  CALC  | iterating, cnt counts remaining steps down to 0
//  DONE  | result presented, held until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CNT_W = cnt_width(N);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     rr, qr, d;
  logic             dz, ov;
  logic [N-1:0]     rr_step;
  logic             qbit_step;
  logic [N-1:0]     hi, lo;

  assign hi = dividend[2*N-1:N];
  assign lo = dividend[N-1:0];

  div_step #(.N(N)) u_step (
    .rr      (rr),
    .qbit    (qr[N-1]),
    .d       (d),
    .rr_next (rr_step),
    .q_next  (qbit_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (hi >= divisor) ? DONE : CALC;
      CALC: if (cnt == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      rr  <= '0;
      qr  <= '0;
      d   <= '0;
      dz  <= 1'b0;
      ov  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          d <= divisor;
          // hi >= 0 always holds, so the zero-divisor case must be tested first
          if (divisor == '0) begin
            dz <= 1'b1;
            ov <= 1'b0;
            qr <= '1;
            rr <= lo;
          end else if (hi >= divisor) begin
            dz <= 1'b0;
            ov <= 1'b1;
            qr <= '1;
            rr <= lo;
          end else begin
            dz  <= 1'b0;
            ov  <= 1'b0;
            rr  <= hi;
            qr  <= lo;
            cnt <= CNT_W'(N - 1);
          end
        end
        CALC: begin
          rr  <= rr_step;
          qr  <= {qr[N-2:0], qbit_step};
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = qr;
  assign remainder   = rr;
  assign div_by_zero = dz;
  assign overflow    = ov;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and round-trip checks of seq_divider at N=8 and N=32 with a result scoreboard.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic        sel = 1'b0;
  logic [63:0] dvd = '0;
  logic [31:0] dvs = '0;

  logic        in_ready8, out_valid8, dz8, ov8;
  logic [7:0]  q8, r8;
  logic        in_ready32, out_valid32, dz32, ov32;
  logic [31:0] q32, r32;

  logic        o_valid, o_ready, o_dz, o_ov;
  logic [31:0] o_q, o_r;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_divider #(.N(8)) dut8 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv & ~sel), .in_ready (in_ready8),
    .dividend (dvd[15:0]), .divisor (dvs[7:0]),
    .out_valid (out_valid8), .out_ready (ordy & ~sel),
    .quotient (q8), .remainder (r8),
    .div_by_zero (dz8), .overflow (ov8)
  );

  seq_divider #(.N(32)) dut32 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv & sel), .in_ready (in_ready32),
    .dividend (dvd), .divisor (dvs),
    .out_valid (out_valid32), .out_ready (ordy & sel),
    .quotient (q32), .remainder (r32),
    .div_by_zero (dz32), .overflow (ov32)
  );

  assign o_valid = sel ? out_valid32 : out_valid8;
  assign o_ready = sel ? in_ready32 : in_ready8;
  assign o_q     = sel ? q32 : {24'd0, q8};
  assign o_r     = sel ? r32 : {24'd0, r8};
  assign o_dz    = sel ? dz32 : dz8;
  assign o_ov    = sel ? ov32 : ov8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one division, wait for its result, optionally hold it under backpressure, then drain.
  task automatic divide(input logic s, input logic [63:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eov, input int hold, input string tag);
    exp_t e, got;
    int   w;
    int   lat;
    e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
    e.lat = (edz || eov) ? 1 : (s ? 33 : 9);
    sel = s;
    dvd = a;
    dvs = b;
    iv  = 1'b1;
    w = 0;
    while (!o_ready && w < 100) begin tick(); w++; end
    if (w >= 100) begin
      iv = 1'b0;
      check({tag, "_accept_timeout"}, 64'(o_ready), 64'd1);
      return;
    end
    sb.push_back(e);
    tick();
    iv  = 1'b0;
    dvd = {$urandom, $urandom};
    dvs = $urandom;
    lat = 1;
    while (!o_valid && lat < 100) begin tick(); lat++; end
    got = sb.pop_front();
    if (lat >= 100) begin
      check({tag, "_result_timeout"}, 64'(o_valid), 64'd1);
      return;
    end
    check({tag, "_quotient"}, 64'(o_q), 64'(got.q));
    check({tag, "_remainder"}, 64'(o_r), 64'(got.r));
    check({tag, "_flags"}, {62'd0, o_dz, o_ov}, {62'd0, got.dz, got.ov});
    check({tag, "_latency"}, 64'(lat), 64'(got.lat));
    for (int i = 0; i < hold; i++) begin
      iv = (i == 5);
      tick();
      check({tag, "_hold_qr"}, {o_q, o_r}, {got.q, got.r});
      check({tag, "_hold_ctl"}, {60'd0, o_valid, o_ready, o_dz, o_ov},
            {60'd0, 1'b1, 1'b0, got.dz, got.ov});
    end
    iv   = 1'b0;
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    check({tag, "_drain"}, {62'd0, o_valid, o_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          seen;
    repeat (3) tick();
    check("reset8_ctl", {58'd0, in_ready8, out_valid8, dz8, ov8, 2'b00}, {58'd0, 4'b1000, 2'b00});
    check("reset8_qr", {48'd0, q8, r8}, 64'd0);
    check("reset32_ctl", {60'd0, in_ready32, out_valid32, dz32, ov32}, {60'd0, 4'b1000});
    check("reset32_qr", {q32, r32}, 64'd0);
    rst_n = 1'b1;
    tick();

    divide(0, 64'h0064, 32'h07, 32'h0E, 32'h02, 0, 0, 0, "d100_7");
    divide(0, 64'h1234, 32'h00, 32'hFF, 32'h34, 1, 0, 0, "div0");
    divide(0, 64'h0800, 32'h08, 32'hFF, 32'h00, 0, 1, 0, "ovf");
    divide(0, 64'h0700, 32'h08, 32'hE0, 32'h00, 0, 0, 0, "no_ovf");
    divide(0, 64'h00AB, 32'h01, 32'hAB, 32'h00, 0, 0, 0, "div1");
    divide(0, 64'hFE01, 32'hFF, 32'hFF, 32'h00, 0, 0, 0, "rt8_ff");
    divide(0, 64'h00FF, 32'h10, 32'h0F, 32'h0F, 0, 0, 0, "d255_16");

    divide(0, 64'h0064, 32'h07, 32'h0E, 32'h02, 0, 0, 20, "bp");
    divide(0, 64'h03E8, 32'h0D, 32'h4C, 32'h0C, 0, 0, 0, "after_bp");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom_range(255, 0);
      rb = $urandom_range(255, 1);
      divide(0, 64'(ra * rb), rb, ra, 32'd0, 0, 0, 0, "rt8");
    end

    divide(1, 64'h0000_0001_0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, "ovf32");
    divide(1, 64'h0000_0000_DEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1, 0, 0, "div0_32");
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 0) rb = 32'd1;
      divide(1, 64'(ra) * 64'(rb), rb, ra, 32'd0, 0, 0, 0, "rt32");
    end

    // Abort a division mid-iteration; the discarded result must never appear.
    sel = 1'b0;
    dvd = 64'h0064;
    dvs = 32'h07;
    iv  = 1'b1;
    tick();
    iv = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ctl", {60'd0, o_ready, o_valid, o_dz, o_ov}, {60'd0, 4'b1000});
    check("abort_qr", {o_q, o_r}, 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_valid) seen++;
    end
    check("abort_no_stale", 64'(seen), 64'd0);
    divide(0, 64'h0064, 32'h07, 32'h0E, 32'h02, 0, 0, 0, "post_abort");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
